// File: rtl/vnu_rd_iter_ctrl_if.sv
// Request/response lines between the read-side iteration controller and the
// VNU write-update handshake block.
interface vnu_rd_iter_ctrl_if;
    logic vnu_init_load_en;
    logic vnu_rd_finish;
    logic iter_update;
    logic vnu_wr;
    logic init_load;
    logic pipe_load;

    modport master (
        output vnu_init_load_en,
        output vnu_rd_finish,
        output iter_update,
        input  vnu_wr,
        input  init_load,
        input  pipe_load
    );

    modport slave (
        input  vnu_init_load_en,
        input  vnu_rd_finish,
        input  iter_update,
        output vnu_wr,
        output init_load,
        output pipe_load
    );
endinterface

// File: rtl/vnu_rd_iter_ctrl.sv
// Read-side decoding controller: initial load, per-iteration LUT stage reads,
// iteration update and early stop, with a watchdog on every handshake wait.
module vnu_rd_iter_ctrl #(
    parameter int ITER_MAX  = 10,
    parameter int ITER_W    = 4,
    parameter int RD_STAGES = 4,
    parameter int STG_W     = 2,
    parameter int WAIT_MAX  = 63,
    parameter int WAIT_W    = 6
) (
    input  logic                   read_clk,
    input  logic                   rstn,
    vnu_rd_iter_ctrl_if.master     hs,
    input  logic                   dec_start_i,
    input  logic                   dec_stop_i,
    output logic                   vnu_rd_en_o,
    output logic [STG_W-1:0]       vnu_rd_stage_o,
    output logic [ITER_W-1:0]      iter_cnt_o,
    output logic                   dec_busy_o,
    output logic                   dec_done_o,
    output logic                   err_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT_LOAD, S_INIT_WAIT, S_READ, S_RD_WAIT, S_ITER_UP, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                vnu_wr_q;
    logic [WAIT_W-1:0]   wd_q, wd_d;
    logic [STG_W-1:0]    stage_q, stage_d;
    logic [ITER_W-1:0]   iter_cnt_q, iter_cnt_d;
    logic                pipe_seen_q, pipe_seen_d;
    logic                stop_q, stop_d;
    logic                iter_upd_q, iter_upd_d;
    logic                init_en_q, init_en_d;
    logic                rd_fin_q, rd_fin_d;
    logic                rd_en_q, rd_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic wr_done, wd_hit, timeout, start_acc, hold;

    // The write strobe's falling edge marks completion of the block's write-back.
    assign wr_done   = vnu_wr_q & ~hs.vnu_wr;
    assign wd_hit    = (wd_q == WAIT_W'(WAIT_MAX - 1));
    assign start_acc = (state_q == S_IDLE) & dec_start_i;

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            vnu_wr_q    <= 1'b0;
            wd_q        <= '0;
            stage_q     <= '0;
            iter_cnt_q  <= '0;
            pipe_seen_q <= 1'b0;
            stop_q      <= 1'b0;
            iter_upd_q  <= 1'b0;
            init_en_q   <= 1'b0;
            rd_fin_q    <= 1'b0;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            vnu_wr_q    <= hs.vnu_wr;
            wd_q        <= wd_d;
            stage_q     <= stage_d;
            iter_cnt_q  <= iter_cnt_d;
            pipe_seen_q <= pipe_seen_d;
            stop_q      <= stop_d;
            iter_upd_q  <= iter_upd_d;
            init_en_q   <= init_en_d;
            rd_fin_q    <= rd_fin_d;
            rd_en_q     <= rd_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            S_IDLE:      if (dec_start_i) state_d = S_INIT_LOAD;
            S_INIT_LOAD: begin
                if (hs.init_load)  state_d = S_INIT_WAIT;
                else if (wd_hit) begin state_d = S_DONE; timeout = 1'b1; end
            end
            S_INIT_WAIT: begin
                if (wr_done)       state_d = S_READ;
                else if (wd_hit) begin state_d = S_DONE; timeout = 1'b1; end
            end
            S_READ:      if (stage_q == STG_W'(RD_STAGES - 1)) state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                // A write completion only counts once the pipeline load is acknowledged.
                if ((pipe_seen_q | hs.pipe_load) & wr_done) state_d = S_ITER_UP;
                else if (wd_hit) begin state_d = S_DONE; timeout = 1'b1; end
            end
            S_ITER_UP: begin
                if ((iter_cnt_q == ITER_W'(ITER_MAX)) || stop_q) state_d = S_DONE;
                else                                             state_d = S_READ;
            end
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hold        = (state_d == state_q);
        wd_d        = '0;
        if (hold && (state_q inside {S_INIT_LOAD, S_INIT_WAIT, S_RD_WAIT}))
            wd_d = wd_q + 1'b1;
        stage_d     = (hold && state_q == S_READ) ? stage_q + 1'b1 : '0;
        pipe_seen_d = hold && (state_q == S_RD_WAIT) && (pipe_seen_q | hs.pipe_load);
        stop_d      = start_acc ? 1'b0
                    : stop_q | (dec_stop_i & ((state_q == S_READ) | (state_q == S_RD_WAIT)));
        iter_cnt_d  = start_acc ? '0
                    : (state_d == S_ITER_UP) ? iter_cnt_q + 1'b1 : iter_cnt_q;
        iter_upd_d  = iter_upd_q ^ (state_d == S_ITER_UP);
        err_d       = start_acc ? 1'b0 : (err_q | timeout);
        // Outputs are decoded from the next state so every output is a flop.
        init_en_d   = (state_d == S_INIT_LOAD);
        rd_fin_d    = (state_d == S_RD_WAIT) & ~pipe_seen_d;
        rd_en_d     = (state_d == S_READ);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    assign hs.vnu_init_load_en = init_en_q;
    assign hs.vnu_rd_finish    = rd_fin_q;
    assign hs.iter_update      = iter_upd_q;
    assign vnu_rd_en_o         = rd_en_q;
    assign vnu_rd_stage_o      = stage_q;
    assign iter_cnt_o          = iter_cnt_q;
    assign dec_busy_o          = busy_q;
    assign dec_done_o          = done_q;
    assign err_o               = err_q;

endmodule
